uart_tx_fifo: RTL

Parametrised UART transmitter: accepts words over a valid/ready handshake into a small FIFO and serialises them LSB-first with a runtime-programmable baud divisor, optional parity and one or two stop bits. It replaces the fixed 8N1 transmitter. It sits between the processor-side peripheral bus logic and the board-level TX pin, and adds back-to-back frames with no idle gap between them.

---
 rtl/uart_tx_fifo.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO, programmable divisor, stop bits and optional parity.
// Define UART_TX_PARITY_EN to compile in the parity generator and the PARITY state.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DIV_WIDTH-1:0]          baud_div_i,
  input  logic                          stop2_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          tx_valid_i,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP1, S_STOP2} state_e;
`endif

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 full, empty, push, pop;

  // Frame registers
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 stop2_q, stop2_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tick, start_frame, end_of_frame;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode_i;
`endif

  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign push         = tx_valid_i & ~full;
  assign tick         = (baud_cnt_q == div_q);
  assign tx_ready_o   = ~full;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state logic; a new frame may start from IDLE or directly out of the last stop bit
  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    div_d        = div_q;
    stop2_d      = stop2_q;
    word_d       = word_q;
    bit_idx_d    = bit_idx_q;
    start_frame  = 1'b0;
    end_of_frame = 1'b0;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
`endif

    if (state_q != S_IDLE) begin
      baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_WIDTH'(1);
    end else begin
      baud_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) start_frame = 1'b1;
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP1;
`else
            state_d = S_STOP1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP1;
      end
`endif
      S_STOP1: begin
        if (tick) begin
          if (stop2_q) state_d = S_STOP2;
          else         end_of_frame = 1'b1;
        end
      end
      S_STOP2: begin
        if (tick) end_of_frame = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_of_frame) begin
      if (!empty) start_frame = 1'b1;
      else        state_d = S_IDLE;
    end

    if (start_frame) begin
      pop        = 1'b1;
      state_d    = S_START;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
      word_d     = mem[rd_ptr_q];
      div_d      = baud_div_i;
      stop2_d    = stop2_i;
`ifdef UART_TX_PARITY_EN
      par_en_d   = (parity_mode_i == 2'd1) || (parity_mode_i == 2'd2);
      par_odd_d  = (parity_mode_i == 2'd1);
`endif
    end
  end

  // Line level is decoded from the next state so tx comes straight from a flop
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = word_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = (^word_d) ^ par_odd_d;
`endif
      S_STOP1:  tx_d = 1'b1;
      S_STOP2:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      word_q     <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      stop2_q    <= stop2_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
`endif
    end
  end

endmodule
